// File: rtl/dl_pkg.sv
// Shared register-file definitions: index width, register count and index type.
package dl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/dl_mux32.sv
// 32:1 word selector used by each register-file read port.
module dl_mux32
    import dl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [NUM_REGS-1:0][W-1:0] i_data,
    input  reg_idx_t                   i_sel,
    output logic [W-1:0]               o_data
);

    // Every 5-bit select value maps to a real input, so the output is never X.
    assign o_data = i_data[i_sel];

endmodule

// File: rtl/dl_regfile_2r1w.sv
// 32-entry, 2-read/1-write integer register file with a per-entry pending
// (scoreboard) bit. Entry 0 reads as zero and is never pending.
module dl_regfile_2r1w
    import dl_pkg::*;
#(
    parameter int                  NUM_BITS  = 32,
    parameter bit                  BYPASS    = 1'b1,
    parameter logic [NUM_BITS-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  reg_idx_t            wr_addr,
    input  logic [NUM_BITS-1:0] wr_data,
    input  logic                rsv_en,
    input  reg_idx_t            rsv_addr,
    input  reg_idx_t            rd0_addr,
    output logic [NUM_BITS-1:0] rd0_data,
    output logic                rd0_pend,
    input  reg_idx_t            rd1_addr,
    output logic [NUM_BITS-1:0] rd1_data,
    output logic                rd1_pend
);

    logic [NUM_BITS-1:0] r_mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] r_pend;

    logic [NUM_REGS-1:0][NUM_BITS-1:0] w_mem_flat;
    logic [NUM_REGS-1:0]               w_pend_flat;
    logic [NUM_BITS-1:0]               w_rd0_stored;
    logic [NUM_BITS-1:0]               w_rd1_stored;
    logic                              w_wr_live;
    logic                              w_rsv_live;
    logic                              w_byp0;
    logic                              w_byp1;

    // Writes and reservations to x0 are dropped here so storage never holds entry 0.
    assign w_wr_live  = wr_en  && (wr_addr  != '0);
    assign w_rsv_live = rsv_en && (rsv_addr != '0);

    // Storage and scoreboard update; a reserve is applied after the write so a
    // same-index write+reserve leaves the entry pending for the new producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_mem[i] <= RESET_VAL;
            end
            r_pend <= '0;
        end else begin
            if (w_wr_live) begin
                r_mem[wr_addr]  <= wr_data;
                r_pend[wr_addr] <= 1'b0;
            end
            if (w_rsv_live) begin
                r_pend[rsv_addr] <= 1'b1;
            end
        end
    end

    // Present all 32 entries to the selectors with entry 0 tied to zero.
    always_comb begin
        w_mem_flat[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_mem_flat[i] = r_mem[i];
        end
    end

    assign w_pend_flat = {r_pend, 1'b0};

    dl_mux32 #(.W(NUM_BITS)) u_mux_rd0 (
        .i_data (w_mem_flat),
        .i_sel  (rd0_addr),
        .o_data (w_rd0_stored)
    );

    dl_mux32 #(.W(NUM_BITS)) u_mux_rd1 (
        .i_data (w_mem_flat),
        .i_sel  (rd1_addr),
        .o_data (w_rd1_stored)
    );

    // Forward the in-flight write to a matching read port; the write clears the
    // pending bit, so a forwarded read is never pending even if a reserve is
    // issued to the same index in this cycle.
    assign w_byp0 = BYPASS && w_wr_live && (wr_addr == rd0_addr);
    assign w_byp1 = BYPASS && w_wr_live && (wr_addr == rd1_addr);

    assign rd0_data = w_byp0 ? wr_data : w_rd0_stored;
    assign rd0_pend = w_byp0 ? 1'b0    : w_pend_flat[rd0_addr];
    assign rd1_data = w_byp1 ? wr_data : w_rd1_stored;
    assign rd1_pend = w_byp1 ? 1'b0    : w_pend_flat[rd1_addr];

endmodule

// File: tb/tb_dl_regfile_2r1w.sv
// Randomised and directed bench for dl_regfile_2r1w. Two instances share all
// inputs: A forwards same-cycle writes with RESET_VAL=0, B does not forward and
// resets to a non-zero pattern.
module tb_dl_regfile_2r1w;

    localparam logic [31:0] RV_B = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  rd0_addr;
    logic [4:0]  rd1_addr;

    logic [31:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
    logic        a_rd0_pend, a_rd1_pend, b_rd0_pend, b_rd1_pend;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: index 0 = instance A, 1 = instance B.
    logic [31:0] m_mem  [2][32];
    logic        m_pend [2][32];

    always #5 clk = ~clk;

    dl_regfile_2r1w #(.NUM_BITS(32), .BYPASS(1'b1), .RESET_VAL(32'h0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_pend(a_rd0_pend),
        .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_pend(a_rd1_pend)
    );

    dl_regfile_2r1w #(.NUM_BITS(32), .BYPASS(1'b0), .RESET_VAL(RV_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_pend(b_rd0_pend),
        .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_pend(b_rd1_pend)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[0][i]  = 32'h0;
            m_mem[1][i]  = (i == 0) ? 32'h0 : RV_B;
            m_pend[0][i] = 1'b0;
            m_pend[1][i] = 1'b0;
        end
    endfunction

    // What a read port must show this cycle, from architectural state plus forwarding.
    function automatic logic [31:0] exp_data(input int inst, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (inst == 0 && rst_n && wr_en && wr_addr == a) return wr_data;
        return m_mem[inst][a];
    endfunction

    function automatic logic exp_pend(input int inst, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (inst == 0 && rst_n && wr_en && wr_addr == a) return 1'b0;
        return m_pend[inst][a];
    endfunction

    task automatic check_ports(input string tag);
        chk({tag, "_a_d0"}, a_rd0_data, exp_data(0, rd0_addr));
        chk({tag, "_a_d1"}, a_rd1_data, exp_data(0, rd1_addr));
        chk({tag, "_b_d0"}, b_rd0_data, exp_data(1, rd0_addr));
        chk({tag, "_b_d1"}, b_rd1_data, exp_data(1, rd1_addr));
        chk({tag, "_a_p0"}, {31'b0, a_rd0_pend}, {31'b0, exp_pend(0, rd0_addr)});
        chk({tag, "_a_p1"}, {31'b0, a_rd1_pend}, {31'b0, exp_pend(0, rd1_addr)});
        chk({tag, "_b_p0"}, {31'b0, b_rd0_pend}, {31'b0, exp_pend(1, rd0_addr)});
        chk({tag, "_b_p1"}, {31'b0, b_rd1_pend}, {31'b0, exp_pend(1, rd1_addr)});
    endtask

    // Apply one cycle of inputs away from the rising edge and check the reads.
    task automatic drive(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re, input logic [4:0] ra,
                         input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd0_addr = a0; rd1_addr = a1;
        #1;
        check_ports(tag);
    endtask

    // Let the rising edge happen and advance the reference state.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en && wr_addr != 5'd0) begin
                    m_mem[k][wr_addr]  = wr_data;
                    m_pend[k][wr_addr] = 1'b0;
                end
                if (rsv_en && rsv_addr != 5'd0) m_pend[k][rsv_addr] = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd0_addr = '0; rd1_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset contents visible on every index of both ports.
        for (int i = 0; i < 32; i++) begin
            drive("rst_rd", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            chk("rst_a_zero", a_rd0_data, 32'h0);
            tick();
        end

        // Write x5, read it back the following cycle.
        drive("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drive("rd5", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        chk("rd5_a", a_rd0_data, 32'hDEAD_BEEF);
        chk("rd5_b", b_rd0_data, 32'hDEAD_BEEF);
        chk("rd5_pend", {31'b0, a_rd0_pend}, 32'h0);
        tick();

        // Writes to x0 are discarded, including the forwarding path.
        drive("wr0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("x0_same", a_rd1_data, 32'h0);
        tick();
        drive("rd0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("x0_next_a", a_rd1_data, 32'h0);
        chk("x0_next_b", b_rd1_data, 32'h0);
        tick();

        // Forwarding: A sees the new value at once, B the stored value until the edge.
        drive("byp7", 1'b1, 5'd7, 32'h0000_1234, 1'b0, 5'd0, 5'd7, 5'd3);
        chk("byp7_a", a_rd0_data, 32'h0000_1234);
        chk("byp7_b_old", b_rd0_data, RV_B);
        tick();
        drive("byp7n", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        chk("byp7_b_new", b_rd0_data, 32'h0000_1234);
        tick();

        // Scoreboard: reserve, clear by write, then write+reserve in one cycle.
        drive("rsv9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9);
        tick();
        drive("pend9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        chk("pend9_set", {31'b0, a_rd1_pend}, 32'h1);
        tick();
        drive("wr9", 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 5'd9);
        chk("wr9_byp_pend", {31'b0, a_rd1_pend}, 32'h0);
        chk("wr9_nobyp_pend", {31'b0, b_rd1_pend}, 32'h1);
        tick();
        drive("pend9c", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        chk("pend9_clr", {31'b0, b_rd1_pend}, 32'h0);
        tick();
        drive("wrrsv9", 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd9, 5'd9, 5'd9);
        chk("wrrsv9_byp_pend", {31'b0, a_rd0_pend}, 32'h0);
        tick();
        drive("wrrsv9n", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        chk("wrrsv9_pend", {31'b0, a_rd1_pend}, 32'h1);
        chk("wrrsv9_data", b_rd1_data, 32'h0000_0999);
        tick();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive("rnd", 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom),
                  5'($urandom), 5'($urandom));
            tick();
        end

        // Populate x1..x31, then reserve a few entries.
        for (int i = 1; i < 32; i++) begin
            drive("fill", 1'b1, 5'(i), $urandom | 32'h1, 1'b0, 5'd0, 5'(i), 5'd0);
            tick();
        end
        for (int i = 1; i < 32; i += 5) begin
            drive("fillrsv", 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i), 5'(i));
            tick();
        end

        // Asynchronous reset between edges: state clears before the next rising edge.
        @(negedge clk);
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd4;
        rd0_addr = 5'd1; rd1_addr = 5'd31;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_a_d0", a_rd0_data, 32'h0);
        chk("arst_b_d1", b_rd1_data, RV_B);
        chk("arst_b_p0", {31'b0, b_rd0_pend}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd0_addr = 5'(i); rd1_addr = 5'(i);
            #1;
            check_ports("arst");
        end
        // A write held across an edge during reset must not land.
        @(negedge clk);
        rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
        rd0_addr = 5'd0; rd1_addr = 5'd0;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        drive("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        chk("post_rst_x3", b_rd0_data, RV_B);
        chk("post_rst_p4", {31'b0, a_rd1_pend}, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
